// File: rtl/uart_transmitter.sv
// uart_transmitter: frames parallel words onto a serial line as
// start bit, data LSB first, optional parity bit and stop bits.
module uart_transmitter #(
   parameter int DATA_WIDTH   = 8,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_pin,
   output logic                  tx_busy
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
   localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic ODD = (PARITY_ODD != 0);
   localparam logic HAS_PAR = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state;
   logic [BW-1:0]         baud_cnt;
   logic [3:0]            bit_cnt;
   logic [DATA_WIDTH-1:0] shift;
   logic                  parity_bit;
   logic                  bit_end;

   assign bit_end = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
         tx_pin     <= 1'b1;
         tx_ready   <= 1'b1;
         tx_busy    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               tx_pin   <= 1'b1;
               if (tx_valid && tx_ready) begin
                  shift      <= tx_data;
                  parity_bit <= ^tx_data ^ ODD;
                  state      <= START;
                  tx_pin     <= 1'b0;
                  tx_ready   <= 1'b0;
                  tx_busy    <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state    <= DATA;
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx_pin   <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[DATA_WIDTH-1:1]};
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     if (HAS_PAR) begin
                        state  <= PARITY;
                        tx_pin <= parity_bit;
                     end else begin
                        state  <= STOP;
                        tx_pin <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     // next bit is still one position up
                     tx_pin  <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state    <= STOP;
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx_pin   <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               tx_pin <= 1'b1;
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     state    <= IDLE;
                     bit_cnt  <= '0;
                     tx_ready <= 1'b1;
                     tx_busy  <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               tx_pin   <= 1'b1;
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: table vectors, hand sequences and random
// words on four configurations, checked against a frame model.
module tb_uart_transmitter;

   typedef struct {
      int dw;
      int sb;
      int cpb;
      int pe;
      int po;
   } cfg_t;

   typedef struct {
      int          idx;
      int          word;
      logic [15:0] lv;
      int          n;
      string       nm;
   } vec_t;

   logic       clk;
   logic       reset_n;
   logic [7:0] data [4];
   logic       valid [4];
   wire        pin [4];
   wire        rdy [4];
   wire        busy [4];

   cfg_t cfg [4];
   vec_t vecs [6];
   bit   exp_q [$];
   int   n_pass;
   int   n_tot;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_transmitter #(.DATA_WIDTH(8), .STOP_BITS(1), .CLKS_PER_BIT(4),
      .PARITY_EN(0), .PARITY_ODD(0)) u0 (
      .clk(clk), .reset_n(reset_n), .tx_data(data[0]),
      .tx_valid(valid[0]), .tx_ready(rdy[0]), .tx_pin(pin[0]),
      .tx_busy(busy[0]));

   uart_transmitter #(.DATA_WIDTH(8), .STOP_BITS(1), .CLKS_PER_BIT(4),
      .PARITY_EN(1), .PARITY_ODD(0)) u1 (
      .clk(clk), .reset_n(reset_n), .tx_data(data[1]),
      .tx_valid(valid[1]), .tx_ready(rdy[1]), .tx_pin(pin[1]),
      .tx_busy(busy[1]));

   uart_transmitter #(.DATA_WIDTH(8), .STOP_BITS(1), .CLKS_PER_BIT(4),
      .PARITY_EN(1), .PARITY_ODD(1)) u2 (
      .clk(clk), .reset_n(reset_n), .tx_data(data[2]),
      .tx_valid(valid[2]), .tx_ready(rdy[2]), .tx_pin(pin[2]),
      .tx_busy(busy[2]));

   uart_transmitter #(.DATA_WIDTH(8), .STOP_BITS(2), .CLKS_PER_BIT(5),
      .PARITY_EN(0), .PARITY_ODD(0)) u3 (
      .clk(clk), .reset_n(reset_n), .tx_data(data[3]),
      .tx_valid(valid[3]), .tx_ready(rdy[3]), .tx_pin(pin[3]),
      .tx_busy(busy[3]));

   task automatic chk(string nm, int idx, logic ep, logic er);
      logic eb;
      eb = !er;
      n_tot++;
      if (pin[idx] === ep && rdy[idx] === er && busy[idx] === eb)
         n_pass++;
      else
         $display("FAIL %s dut%0d t=%0t: got pin=%b ready=%b busy=%b, want pin=%b ready=%b busy=%b",
                  nm, idx, $time, pin[idx], rdy[idx], busy[idx], ep, er, eb);
   endtask

   task automatic chk_int(string nm, int got, int want);
      n_tot++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", nm, got, want);
   endtask

   // expected line levels, one entry per bit period
   function automatic void load_model(int idx, int w);
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < cfg[idx].dw; i++)
         exp_q.push_back(bit'((w >> i) & 1));
      if (cfg[idx].pe != 0)
         exp_q.push_back(bit'(($countones(w) + cfg[idx].po) % 2));
      for (int i = 0; i < cfg[idx].sb; i++)
         exp_q.push_back(1'b1);
   endfunction

   function automatic void load_vec(vec_t v);
      exp_q.delete();
      for (int i = 0; i < v.n; i++) exp_q.push_back(v.lv[i]);
   endfunction

   task automatic accept(int idx, int w, output int waited);
      data[idx]  = 8'(w);
      valid[idx] = 1'b1;
      waited = 0;
      while (rdy[idx] !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      n_tot++;
      if (rdy[idx] === 1'b1) n_pass++;
      else $display("FAIL accept_timeout dut%0d: got ready=%b, want 1", idx, rdy[idx]);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_frame(int idx, string nm);
      foreach (exp_q[i])
         for (int c = 0; c < cfg[idx].cpb; c++) begin
            chk(nm, idx, exp_q[i], 1'b0);
            @(negedge clk);
         end
      chk({nm, "_idle"}, idx, 1'b1, 1'b1);
   endtask

   initial begin
      int w;
      int idx;
      int waited;
      n_pass = 0;
      n_tot  = 0;
      cfg[0] = '{8, 1, 4, 0, 0};
      cfg[1] = '{8, 1, 4, 1, 0};
      cfg[2] = '{8, 1, 4, 1, 1};
      cfg[3] = '{8, 2, 5, 0, 0};
      vecs[0] = '{0, 'hA5, 16'b1101001010, 10, "a5"};
      vecs[1] = '{1, 'h07, 16'b11000001110, 11, "par_even_07"};
      vecs[2] = '{2, 'h07, 16'b10000001110, 11, "par_odd_07"};
      vecs[3] = '{3, 'h00, 16'b11000000000, 11, "stop2_00"};
      vecs[4] = '{0, 'hFF, 16'b1111111110, 10, "ff"};
      vecs[5] = '{1, 'h00, 16'b10000000000, 11, "par_even_00"};
      for (int i = 0; i < 4; i++) begin
         data[i]  = 8'h00;
         valid[i] = 1'b0;
      end

      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) chk("in_reset", i, 1'b1, 1'b1);
      reset_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) chk("idle_line", i, 1'b1, 1'b1);
      end

      foreach (vecs[v]) begin
         accept(vecs[v].idx, vecs[v].word, waited);
         valid[vecs[v].idx] = 1'b0;
         data[vecs[v].idx]  = ~8'(vecs[v].word);
         load_vec(vecs[v]);
         run_frame(vecs[v].idx, vecs[v].nm);
      end

      accept(0, 'h55, waited);
      data[0] = 8'hAA;
      load_model(0, 'h55);
      run_frame(0, "b2b_55");
      accept(0, 'hAA, waited);
      chk_int("b2b_gap", waited, 0);
      valid[0] = 1'b0;
      data[0]  = 8'h00;
      load_model(0, 'hAA);
      run_frame(0, "b2b_aa");

      accept(0, 'hFF, waited);
      valid[0] = 1'b0;
      repeat (17) @(negedge clk);
      chk("bit3_before_reset", 0, 1'b1, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) chk("async_reset", i, 1'b1, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("after_reset", 0, 1'b1, 1'b1);
      accept(0, 'h3C, waited);
      valid[0] = 1'b0;
      load_model(0, 'h3C);
      run_frame(0, "post_reset_3c");

      for (int r = 0; r < 24; r++) begin
         idx = int'($urandom_range(3, 0));
         w   = int'($urandom) & ((1 << cfg[idx].dw) - 1);
         accept(idx, w, waited);
         valid[idx] = 1'b0;
         data[idx]  = 8'($urandom);
         load_model(idx, w);
         run_frame(idx, "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
